// File: rtl/alu_op_sequencer.sv
// Fetch/execute control-step sequencer for ALU instructions (T0..T6 strobes).
// Define SEQ_HILO_EN to build the mul/div class (T6, LOin/HIin/ZHighOut).
module alu_op_sequencer #(
   parameter int NUM_REGS = 16,
   parameter int OPW      = 5,
   localparam int RW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                clock,
   input  logic                clear,
   input  logic                start,
   input  logic                mem_ready,
   input  logic [31:0]         ir,
   output logic [NUM_REGS-1:0] Rin,
   output logic [NUM_REGS-1:0] Rout,
   output logic                PCout,
   output logic                PCin,
   output logic                incPC,
   output logic                MARin,
   output logic                MDRin,
   output logic                MDRout,
   output logic                read,
   output logic                IRin,
   output logic                Yin,
   output logic                Zin,
   output logic                ZLowOut,
   output logic                ZHighOut,
   output logic                HIin,
   output logic                LOin,
   output logic [OPW-1:0]      opcode,
   output logic                busy,
   output logic                done,
   output logic                illegal
);

   // T1W is the memory-wait copy of T1 without PCin, keeping the machine Moore.
   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5,
`ifdef SEQ_HILO_EN
      S_T6,
`endif
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [OPW-1:0] w_opc;
   logic [RW-1:0]  w_ra, w_rb, w_rc;
   logic           w_raOk, w_rbOk, w_rcOk;
   logic           w_binOk, w_unOk, w_mdOk;
   logic           w_unused;

   assign w_opc    = ir[31 -: OPW];
   assign w_ra     = ir[31-OPW -: RW];
   assign w_rb     = ir[31-OPW-RW -: RW];
   assign w_rc     = ir[31-OPW-2*RW -: RW];
   assign w_unused = ^ir[31-OPW-3*RW:0];

   assign w_raOk = ({1'b0, w_ra} < (RW+1)'(NUM_REGS));
   assign w_rbOk = ({1'b0, w_rb} < (RW+1)'(NUM_REGS));
   assign w_rcOk = ({1'b0, w_rc} < (RW+1)'(NUM_REGS));

   assign w_binOk = (w_opc >= OPW'(3)) && (w_opc <= OPW'(14)) && w_raOk && w_rbOk && w_rcOk;
   assign w_unOk  = ((w_opc == OPW'(17)) || (w_opc == OPW'(18))) && w_raOk && w_rbOk;
`ifdef SEQ_HILO_EN
   assign w_mdOk  = ((w_opc == OPW'(15)) || (w_opc == OPW'(16))) && w_rbOk && w_rcOk;
`else
   assign w_mdOk  = 1'b0;
`endif

   function automatic logic [NUM_REGS-1:0] oneHot(input logic [RW-1:0] idx);
      return NUM_REGS'(1) << idx;
   endfunction

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (start) w_next = S_T0;
         S_T0:        w_next = S_T1;
         S_T1, S_T1W: w_next = mem_ready ? S_T2 : S_T1W;
         S_T2:        w_next = S_T3;
         S_T3: begin
            if (w_binOk || w_mdOk) w_next = S_T4;
            else if (w_unOk)       w_next = S_T5;
            else                   w_next = S_IDLE;
         end
         S_T4:        w_next = S_T5;
`ifdef SEQ_HILO_EN
         S_T5:        w_next = w_mdOk ? S_T6 : S_DONE;
         S_T6:        w_next = S_DONE;
`else
         S_T5:        w_next = S_DONE;
`endif
         S_DONE:      w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_comb begin
      Rin     = '0;
      Rout    = '0;
      PCout   = 1'b0;
      PCin    = 1'b0;
      incPC   = 1'b0;
      MARin   = 1'b0;
      MDRin   = 1'b0;
      MDRout  = 1'b0;
      read    = 1'b0;
      IRin    = 1'b0;
      Yin     = 1'b0;
      Zin     = 1'b0;
      ZLowOut = 1'b0;
`ifdef SEQ_HILO_EN
      ZHighOut = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
`endif
      opcode  = '0;
      busy    = (r_state != S_IDLE);
      done    = 1'b0;
      illegal = 1'b0;
      case (r_state)
         S_T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            incPC = 1'b1;
            Zin   = 1'b1;
         end
         S_T1, S_T1W: begin
            ZLowOut = 1'b1;
            PCin    = (r_state == S_T1);
            read    = 1'b1;
            MDRin   = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T3: begin
            if (w_unOk) begin
               Rout   = oneHot(w_rb);
               opcode = w_opc;
               Zin    = 1'b1;
            end else if (w_binOk || w_mdOk) begin
               Rout = oneHot(w_rb);
               Yin  = 1'b1;
            end else begin
               illegal = 1'b1;
            end
         end
         S_T4: begin
            Rout   = oneHot(w_rc);
            opcode = w_opc;
            Zin    = 1'b1;
         end
         S_T5: begin
            ZLowOut = 1'b1;
`ifdef SEQ_HILO_EN
            if (w_mdOk) LOin = 1'b1;
            else        Rin  = oneHot(w_ra);
`else
            Rin = oneHot(w_ra);
`endif
         end
`ifdef SEQ_HILO_EN
         S_T6: begin
            ZHighOut = 1'b1;
            HIin     = 1'b1;
         end
`endif
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

`ifndef SEQ_HILO_EN
   assign ZHighOut = 1'b0;
   assign HIin     = 1'b0;
   assign LOin     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed cases plus random instructions
// compared cycle by cycle against an instruction-level expected-strobe model.
module tb_alu_op_sequencer;

   typedef struct packed {
      logic [15:0] rin;
      logic [15:0] rout;
      logic pcOut, pcIn, incPc, marIn, mdrIn, mdrOut, rd, irIn;
      logic yIn, zIn, zLowOut, zHighOut, hiIn, loIn;
      logic [4:0] opc;
      logic busy, done, illegal;
   } outs_t;

   logic        clock = 1'b0;
   logic        clear, start, mem_ready;
   logic [31:0] ir;
   logic [15:0] Rin, Rout;
   logic PCout, PCin, incPC, MARin, MDRin, MDRout, read, IRin;
   logic Yin, Zin, ZLowOut, ZHighOut, HIin, LOin;
   logic [4:0]  opcode;
   logic        busy, done, illegal;

   int    vectors = 0;
   int    miscompares = 0;
   outs_t expQ[$];

   alu_op_sequencer #(.NUM_REGS(16), .OPW(5)) dut (
      .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
      .Rin(Rin), .Rout(Rout), .PCout(PCout), .PCin(PCin), .incPC(incPC),
      .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .read(read), .IRin(IRin),
      .Yin(Yin), .Zin(Zin), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut),
      .HIin(HIin), .LOin(LOin), .opcode(opcode), .busy(busy), .done(done),
      .illegal(illegal)
   );

   always #5 clock = ~clock;

   function automatic outs_t observed();
      outs_t o;
      o.rin = Rin;       o.rout = Rout;
      o.pcOut = PCout;   o.pcIn = PCin;     o.incPc = incPC;   o.marIn = MARin;
      o.mdrIn = MDRin;   o.mdrOut = MDRout; o.rd = read;       o.irIn = IRin;
      o.yIn = Yin;       o.zIn = Zin;       o.zLowOut = ZLowOut;
      o.zHighOut = ZHighOut; o.hiIn = HIin; o.loIn = LOin;
      o.opc = opcode;    o.busy = busy;     o.done = done;     o.illegal = illegal;
      return o;
   endfunction

   // Expected per-cycle strobes for a whole instruction, straight from the step table.
   task automatic buildExpected(input logic [31:0] instr, input int waits);
      outs_t o;
      int opc, ra, rb, rc;
      bit isBin, isUn, isMd;
      opc = int'(instr[31:27]);
      ra  = int'(instr[26:23]);
      rb  = int'(instr[22:19]);
      rc  = int'(instr[18:15]);
      isBin = (opc >= 3 && opc <= 14);
      isUn  = (opc == 17 || opc == 18);
`ifdef SEQ_HILO_EN
      isMd  = (opc == 15 || opc == 16);
`else
      isMd  = 1'b0;
`endif
      expQ.delete();
      o = '0; o.busy = 1; o.pcOut = 1; o.marIn = 1; o.incPc = 1; o.zIn = 1;
      expQ.push_back(o);
      for (int w = 0; w <= waits; w++) begin
         o = '0; o.busy = 1; o.zLowOut = 1; o.rd = 1; o.mdrIn = 1; o.pcIn = (w == 0);
         expQ.push_back(o);
      end
      o = '0; o.busy = 1; o.mdrOut = 1; o.irIn = 1;
      expQ.push_back(o);
      o = '0; o.busy = 1;
      if (!(isBin || isUn || isMd)) begin
         o.illegal = 1;
         expQ.push_back(o);
         return;
      end
      o.rout = 16'(1 << rb);
      if (isUn) begin o.opc = 5'(opc); o.zIn = 1; end
      else o.yIn = 1;
      expQ.push_back(o);
      if (!isUn) begin
         o = '0; o.busy = 1; o.rout = 16'(1 << rc); o.opc = 5'(opc); o.zIn = 1;
         expQ.push_back(o);
      end
      o = '0; o.busy = 1; o.zLowOut = 1;
      if (isMd) o.loIn = 1; else o.rin = 16'(1 << ra);
      expQ.push_back(o);
      if (isMd) begin
         o = '0; o.busy = 1; o.zHighOut = 1; o.hiIn = 1;
         expQ.push_back(o);
      end
      o = '0; o.busy = 1; o.done = 1;
      expQ.push_back(o);
   endtask

   task automatic checkOutput(input string tag, input outs_t exp);
      outs_t obs;
      obs = observed();
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input string tag, input logic [31:0] instr, input int waits);
      buildExpected(instr, waits);
      ir = instr;
      start = 1'b1;
      mem_ready = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      for (int i = 0; i < expQ.size(); i++) begin
         start = 1'($urandom_range(0, 1));
         if (i >= 1 && i <= waits) mem_ready = 1'b0;
         else if (i == waits + 1)  mem_ready = 1'b1;
         else                      mem_ready = 1'($urandom_range(0, 1));
         @(negedge clock);
         checkOutput($sformatf("%s.c%0d", tag, i), expQ[i]);
         @(posedge clock); #1;
      end
      start = 1'b0;
      @(negedge clock);
      checkOutput({tag, ".idle"}, '0);
      @(posedge clock); #1;
   endtask

   initial begin
      logic [31:0] instr;
      clear = 1'b0; start = 1'b0; mem_ready = 1'b0; ir = '0;
      #2;
      checkOutput("reset", '0);
      #10 clear = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      checkOutput("idle_after_reset", '0);
      @(posedge clock); #1;

      applyStimulus("add",     {5'b00011, 4'd4, 4'd3, 4'd7, 15'h1234}, 0);
      applyStimulus("neg",     {5'b10001, 4'd5, 4'd0, 4'd9, 15'h0}, 0);
      applyStimulus("mul",     {5'b01111, 4'd2, 4'd6, 4'd11, 15'h0}, 0);
      applyStimulus("div",     {5'b10000, 4'd1, 4'd15, 4'd0, 15'h7fff}, 1);
      applyStimulus("memwait", {5'b00101, 4'd9, 4'd8, 4'd14, 15'h0}, 3);
      applyStimulus("ill31",   {5'b11111, 4'd4, 4'd3, 4'd7, 15'h0}, 0);
      applyStimulus("ill0",    {5'b00000, 4'd1, 4'd2, 4'd3, 15'h0}, 2);
      applyStimulus("not",     {5'b10010, 4'd15, 4'd15, 4'd0, 15'h0}, 0);

      // Abort in T4: outputs drop asynchronously and no done follows.
      instr = {5'b00011, 4'd4, 4'd3, 4'd7, 15'h0};
      buildExpected(instr, 0);
      ir = instr; start = 1'b1; mem_ready = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      for (int i = 0; i <= 4; i++) begin
         @(negedge clock);
         checkOutput($sformatf("abort.c%0d", i), expQ[i]);
         if (i < 4) begin @(posedge clock); #1; end
      end
      #2 clear = 1'b0;
      #1 checkOutput("abort.async", '0);
      @(posedge clock); #1;
      @(negedge clock);
      checkOutput("abort.held", '0);
      #1 clear = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      checkOutput("abort.idle", '0);
      @(posedge clock); #1;
      applyStimulus("after_abort", instr, 0);

      for (int n = 0; n < 40; n++) begin
         instr = {5'($urandom_range(0, 31)), 27'($urandom)};
         applyStimulus($sformatf("rnd%0d", n), instr, int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
